// File: rtl/la_trg_seq.sv
// Multi-stage trigger sequencer: walks up to SN masked-event stages and emits one trigger pulse.
// Optional per-stage timeout and restart counter are built when LA_TRG_SEQ_TMO_EN is defined.
module la_trg_seq #(
    parameter int SN = 4,
    parameter int EW = 4,
    parameter int CW = 16,
    parameter int TW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctl_rst,
    input  logic                  ctl_arm,
    input  logic                  ctl_abt,
    input  logic [EW-1:0]         evn,
    input  logic [$clog2(SN):0]   cfg_num,
    input  logic [SN*EW-1:0]      cfg_msk,
    input  logic [SN*CW-1:0]      cfg_cnt,
    input  logic [SN*TW-1:0]      cfg_tmo,
    output logic                  evn_trg,
    output logic                  sts_run,
    output logic                  sts_don,
    output logic [$clog2(SN)-1:0] sts_stg,
    output logic [CW-1:0]         sts_occ,
    output logic [15:0]           sts_tmo
);

    localparam int NW = $clog2(SN) + 1;
    localparam int SW = $clog2(SN);

    typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stg_q, stg_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          don_q, don_d;
    logic          trg_q, trg_d;
    logic          run_q, run_d;

    logic [EW-1:0] sel_msk;
    logic [CW-1:0] sel_cnt;
    logic [CW-1:0] eff_cnt;
    logic [NW-1:0] eff_num;
    logic          hit;
    logic          done;
    logic          last_stg;
    logic          tmo_hit;
    logic          tmr_clr;
    logic          tmo_inc;
    logic          tmo_clr;

    always_comb begin
        sel_msk = '0;
        sel_cnt = '0;
        for (int k = 0; k < SN; k++) begin
            if (stg_q == SW'(k)) begin
                sel_msk = cfg_msk[k*EW +: EW];
                sel_cnt = cfg_cnt[k*CW +: CW];
            end
        end
    end

    // cfg_num is clamped live, so shrinking it below the current stage makes that stage the last one
    always_comb begin
        if (cfg_num == '0) begin
            eff_num = NW'(1);
        end else if (cfg_num > NW'(SN)) begin
            eff_num = NW'(SN);
        end else begin
            eff_num = cfg_num;
        end
    end

    assign eff_cnt  = (sel_cnt == '0) ? CW'(1) : sel_cnt;
    assign hit      = |(evn & sel_msk);
    assign done     = hit && (({1'b0, occ_q} + (CW+1)'(1)) >= {1'b0, eff_cnt});
    assign last_stg = (NW'(stg_q) + NW'(1)) >= eff_num;

    // Priority: abort, then arm, then completion, then timeout
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        occ_d   = occ_q;
        don_d   = don_q;
        trg_d   = 1'b0;
        tmr_clr = 1'b0;
        tmo_inc = 1'b0;
        tmo_clr = 1'b0;
        if (ctl_abt) begin
            state_d = IDLE;
        end else if (ctl_arm) begin
            state_d = RUN;
            stg_d   = '0;
            occ_d   = '0;
            don_d   = 1'b0;
            tmr_clr = 1'b1;
            tmo_clr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (done) begin
                        occ_d   = '0;
                        tmr_clr = 1'b1;
                        if (last_stg) begin
                            state_d = FIRE;
                            trg_d   = 1'b1;
                            don_d   = 1'b1;
                        end else begin
                            stg_d = stg_q + SW'(1);
                        end
                    end else if (tmo_hit) begin
                        stg_d   = '0;
                        occ_d   = '0;
                        tmr_clr = 1'b1;
                        tmo_inc = 1'b1;
                    end else if (hit) begin
                        occ_d = occ_q + CW'(1);
                    end
                end
                FIRE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        run_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst || ctl_rst) begin
            state_q <= IDLE;
            stg_q   <= '0;
            occ_q   <= '0;
            don_q   <= 1'b0;
            trg_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            occ_q   <= occ_d;
            don_q   <= don_d;
            trg_q   <= trg_d;
            run_q   <= run_d;
        end
    end

`ifdef LA_TRG_SEQ_TMO_EN
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] sel_tmo;
    logic [15:0]   tmo_q, tmo_d;

    always_comb begin
        sel_tmo = '0;
        for (int k = 0; k < SN; k++) begin
            if (stg_q == SW'(k)) begin
                sel_tmo = cfg_tmo[k*TW +: TW];
            end
        end
    end

    assign tmo_hit = (sel_tmo != '0) && (tmr_q == sel_tmo - TW'(1));

    // Timer holds at all-ones rather than wrapping; restart count saturates
    always_comb begin
        tmr_d = tmr_q;
        tmo_d = tmo_q;
        if (tmr_clr) begin
            tmr_d = '0;
        end else if (state_q == RUN && tmr_q != '1) begin
            tmr_d = tmr_q + TW'(1);
        end
        if (tmo_clr) begin
            tmo_d = '0;
        end else if (tmo_inc && tmo_q != 16'hffff) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ctl_rst) begin
            tmr_q <= '0;
            tmo_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end

    assign sts_tmo = tmo_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{cfg_tmo, tmr_clr, tmo_inc, tmo_clr};
    assign sts_tmo    = '0;
`endif

    assign evn_trg = trg_q;
    assign sts_run = run_q;
    assign sts_don = don_q;
    assign sts_stg = stg_q;
    assign sts_occ = occ_q;

endmodule

// File: tb/tb_la_trg_seq.sv
// Bench for la_trg_seq: vector table, directed corner sequences, then random stimulus vs a reference model.
// Timeout sequences are included when LA_TRG_SEQ_TMO_EN is defined.
module tb_la_trg_seq;

    localparam int SN = 4;
    localparam int EW = 4;
    localparam int CW = 16;
    localparam int TW = 32;
`ifdef LA_TRG_SEQ_TMO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic          rst;
        logic          crst;
        logic          arm;
        logic          abt;
        logic [EW-1:0] evn;
    } stim_t;

    typedef struct packed {
        logic          trg;
        logic          run;
        logic          don;
        logic [1:0]    stg;
        logic [CW-1:0] occ;
        logic [15:0]   tmo;
    } outs_t;

    typedef struct packed {
        stim_t stim;
        outs_t exp;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             ctl_rst;
    logic             ctl_arm;
    logic             ctl_abt;
    logic [EW-1:0]    evn;
    logic [2:0]       cfg_num;
    logic [SN*EW-1:0] cfg_msk;
    logic [SN*CW-1:0] cfg_cnt;
    logic [SN*TW-1:0] cfg_tmo;
    logic             evn_trg;
    logic             sts_run;
    logic             sts_don;
    logic [1:0]       sts_stg;
    logic [CW-1:0]    sts_occ;
    logic [15:0]      sts_tmo;

    int n_vec = 0;
    int n_mis = 0;

    bit     m_run;
    bit     m_fire;
    bit     m_don;
    int     m_stage;
    int     m_occ;
    int     m_tmo;
    longint m_timer;

    vec_t tbl[15];

    la_trg_seq #(.SN(SN), .EW(EW), .CW(CW), .TW(TW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctl_rst (ctl_rst),
        .ctl_arm (ctl_arm),
        .ctl_abt (ctl_abt),
        .evn     (evn),
        .cfg_num (cfg_num),
        .cfg_msk (cfg_msk),
        .cfg_cnt (cfg_cnt),
        .cfg_tmo (cfg_tmo),
        .evn_trg (evn_trg),
        .sts_run (sts_run),
        .sts_don (sts_don),
        .sts_stg (sts_stg),
        .sts_occ (sts_occ),
        .sts_tmo (sts_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input bit r, input bit cr, input bit a, input bit b, input logic [EW-1:0] e);
        stim_t s;
        s.rst  = r;
        s.crst = cr;
        s.arm  = a;
        s.abt  = b;
        s.evn  = e;
        return s;
    endfunction

    function automatic outs_t mkOut(input bit t, input bit r, input bit d, input int s, input int o, input int m);
        outs_t x;
        x.trg = t;
        x.run = r;
        x.don = d;
        x.stg = 2'(s);
        x.occ = 16'(o);
        x.tmo = 16'(m);
        return x;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input outs_t o);
        vec_t v;
        v.stim = s;
        v.exp  = o;
        return v;
    endfunction

    task automatic setStage(input int k, input logic [EW-1:0] m, input int c, input int t);
        cfg_msk[k*EW +: EW] = m;
        cfg_cnt[k*CW +: CW] = 16'(c);
        cfg_tmo[k*TW +: TW] = 32'(t);
    endtask

    // Reference behaviour: one clock edge of the sequencer, computed from the event rules
    task automatic modelStep(input stim_t s);
        int     eff_num;
        int     need;
        longint lim;
        bit     hit;
        if (s.rst || s.crst) begin
            m_run = 0; m_fire = 0; m_don = 0;
            m_stage = 0; m_occ = 0; m_tmo = 0; m_timer = 0;
            return;
        end
        eff_num = (int'(cfg_num) == 0) ? 1 : ((int'(cfg_num) > SN) ? SN : int'(cfg_num));
        if (s.abt) begin
            m_run = 0; m_fire = 0;
            return;
        end
        if (s.arm) begin
            m_run = 1; m_fire = 0; m_don = 0;
            m_stage = 0; m_occ = 0; m_timer = 0; m_tmo = 0;
            return;
        end
        if (m_fire) begin
            m_fire = 0; m_run = 0;
            return;
        end
        if (!m_run) return;
        hit  = (s.evn & cfg_msk[m_stage*EW +: EW]) != '0;
        need = int'(cfg_cnt[m_stage*CW +: CW]);
        if (need == 0) need = 1;
        lim  = longint'(cfg_tmo[m_stage*TW +: TW]);
        if (hit && (m_occ + 1 >= need)) begin
            m_occ = 0;
            m_timer = 0;
            if (m_stage + 1 >= eff_num) begin
                m_fire = 1;
                m_don  = 1;
            end else begin
                m_stage = m_stage + 1;
            end
        end else if (TMO_EN && lim != 0 && m_timer == lim - 1) begin
            m_stage = 0; m_occ = 0; m_timer = 0;
            if (m_tmo < 65535) m_tmo = m_tmo + 1;
        end else begin
            if (hit) m_occ = m_occ + 1;
            m_timer = m_timer + 1;
        end
    endtask

    function automatic outs_t modelOut();
        return mkOut(m_fire, m_run, m_don, m_stage, m_occ, m_tmo);
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst     = s.rst;
        ctl_rst = s.crst;
        ctl_arm = s.arm;
        ctl_abt = s.abt;
        evn     = s.evn;
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = {evn_trg, sts_run, sts_don, sts_stg, sts_occ, sts_tmo};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got trg=%0b run=%0b don=%0b stg=%0d occ=%0d tmo=%0d, expected trg=%0b run=%0b don=%0b stg=%0d occ=%0d tmo=%0d",
                     name, act.trg, act.run, act.don, act.stg, act.occ, act.tmo,
                     exp.trg, exp.run, exp.don, exp.stg, exp.occ, exp.tmo);
        end
    endtask

    initial begin
        stim_t s;
        rst = 1'b1; ctl_rst = 1'b0; ctl_arm = 1'b0; ctl_abt = 1'b0; evn = '0;
        cfg_num = 3'd2; cfg_msk = '0; cfg_cnt = '0; cfg_tmo = '0;

        // Basic two-stage sequence, abort and arm-with-hit
        setStage(0, 4'h1, 3, 0);
        setStage(1, 4'h2, 1, 0);
        setStage(2, 4'h4, 1, 0);
        setStage(3, 4'h8, 1, 0);
        tbl[0]  = mkVec(st(1,0,0,0,4'h0), mkOut(0,0,0,0,0,0));
        tbl[1]  = mkVec(st(0,0,1,0,4'h0), mkOut(0,1,0,0,0,0));
        tbl[2]  = mkVec(st(0,0,0,0,4'h1), mkOut(0,1,0,0,1,0));
        tbl[3]  = mkVec(st(0,0,0,0,4'h0), mkOut(0,1,0,0,1,0));
        tbl[4]  = mkVec(st(0,0,0,0,4'h1), mkOut(0,1,0,0,2,0));
        tbl[5]  = mkVec(st(0,0,0,0,4'h2), mkOut(0,1,0,0,2,0));
        tbl[6]  = mkVec(st(0,0,0,0,4'h1), mkOut(0,1,0,1,0,0));
        tbl[7]  = mkVec(st(0,0,0,0,4'h0), mkOut(0,1,0,1,0,0));
        tbl[8]  = mkVec(st(0,0,0,0,4'h2), mkOut(1,1,1,1,0,0));
        tbl[9]  = mkVec(st(0,0,0,0,4'h0), mkOut(0,0,1,1,0,0));
        tbl[10] = mkVec(st(0,0,0,0,4'h2), mkOut(0,0,1,1,0,0));
        tbl[11] = mkVec(st(0,0,1,0,4'h1), mkOut(0,1,0,0,0,0));
        tbl[12] = mkVec(st(0,0,0,0,4'h1), mkOut(0,1,0,0,1,0));
        tbl[13] = mkVec(st(0,0,0,1,4'h1), mkOut(0,0,0,0,1,0));
        tbl[14] = mkVec(st(0,0,0,0,4'h3), mkOut(0,0,0,0,1,0));
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].stim);
            checkOutput($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Completing hit of stage 0 must not count toward stage 1
        cfg_num = 3'd2;
        setStage(0, 4'h1, 1, 0);
        setStage(1, 4'h1, 2, 0);
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("consume_e1", mkOut(0,1,0,1,0,0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("consume_e2", mkOut(0,1,0,1,1,0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("consume_trg", mkOut(1,1,1,1,0,0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("consume_after", mkOut(0,0,1,1,0,0));

        // Abort on the final hit suppresses the trigger
        cfg_num = 3'd1;
        setStage(0, 4'h1, 1, 0);
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,1,4'h1));
        checkOutput("abort_final", mkOut(0,0,0,0,0,0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("abort_idle", mkOut(0,0,0,0,0,0));

        // cfg_num=0 and cnt=0 clamp to one stage, one hit
        cfg_num = 3'd0;
        setStage(0, 4'h2, 0, 0);
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h2));
        checkOutput("clamp_lo_trg", mkOut(1,1,1,0,0,0));
        applyStimulus(st(0,0,0,0,4'h0));
        checkOutput("clamp_lo_after", mkOut(0,0,1,0,0,0));

        // cfg_num=7 clamps to all four stages
        cfg_num = 3'd7;
        for (int k = 0; k < SN; k++) setStage(k, 4'h1, 1, 0);
        applyStimulus(st(0,0,1,0,4'h0));
        for (int i = 1; i < SN; i++) begin
            applyStimulus(st(0,0,0,0,4'h1));
            checkOutput($sformatf("clamp_hi_stg%0d", i), mkOut(0,1,0,i,0,0));
        end
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("clamp_hi_trg", mkOut(1,1,1,3,0,0));

        // Soft reset mid-sequence, then hits without re-arm
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h1));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("crst_pre", mkOut(0,1,0,2,0,0));
        applyStimulus(st(0,1,0,0,4'h1));
        checkOutput("crst_zero", mkOut(0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(st(0,0,0,0,4'h1));
            checkOutput($sformatf("crst_hold%0d", i), mkOut(0,0,0,0,0,0));
        end

        // Arm during FIRE: pulse already out, restart takes effect
        cfg_num = 3'd1;
        setStage(0, 4'h1, 1, 0);
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("rearm_fire", mkOut(1,1,1,0,0,0));
        applyStimulus(st(0,0,1,0,4'h0));
        checkOutput("rearm_run", mkOut(0,1,0,0,0,0));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("rearm_trg", mkOut(1,1,1,0,0,0));
        applyStimulus(st(0,0,0,0,4'h0));
        checkOutput("rearm_after", mkOut(0,0,1,0,0,0));

`ifdef LA_TRG_SEQ_TMO_EN
        // Stage 1 times out after 10 cycles, then a fresh pass completes
        cfg_num = 3'd2;
        setStage(0, 4'h1, 1, 0);
        setStage(1, 4'h2, 1, 10);
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h1));
        for (int i = 0; i < 9; i++) applyStimulus(st(0,0,0,0,4'h0));
        checkOutput("tmo_before", mkOut(0,1,0,1,0,0));
        applyStimulus(st(0,0,0,0,4'h0));
        checkOutput("tmo_reload", mkOut(0,1,0,0,0,1));
        applyStimulus(st(0,0,0,0,4'h1));
        checkOutput("tmo_fresh_s1", mkOut(0,1,0,1,0,1));
        applyStimulus(st(0,0,0,0,4'h2));
        checkOutput("tmo_fresh_trg", mkOut(1,1,1,1,0,1));

        // Completion on the timeout cycle wins
        applyStimulus(st(0,0,1,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h1));
        for (int i = 0; i < 9; i++) applyStimulus(st(0,0,0,0,4'h0));
        applyStimulus(st(0,0,0,0,4'h2));
        checkOutput("tmo_vs_done", mkOut(1,1,1,1,0,0));

        // Stage 0 with no mask times out repeatedly and is counted
        setStage(0, 4'h0, 1, 3);
        applyStimulus(st(0,0,1,0,4'h0));
        for (int i = 0; i < 3; i++) applyStimulus(st(0,0,0,0,4'hf));
        checkOutput("tmo_s0_first", mkOut(0,1,0,0,0,1));
        for (int i = 0; i < 3; i++) applyStimulus(st(0,0,0,0,4'hf));
        checkOutput("tmo_s0_second", mkOut(0,1,0,0,0,2));
`endif

        // Random episodes against the reference model
        for (int ep = 0; ep < 60; ep++) begin
            cfg_num = 3'($urandom_range(0, 7));
            for (int k = 0; k < SN; k++) begin
                setStage(k,
                         ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                         $urandom_range(0, 3),
                         ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8));
            end
            applyStimulus(st(0,0,1,0,4'h0));
            checkOutput("rand_arm", modelOut());
            for (int c = 0; c < 60; c++) begin
                s.rst  = ($urandom_range(0, 299) == 0);
                s.crst = ($urandom_range(0, 199) == 0);
                s.arm  = ($urandom_range(0, 24) == 0);
                s.abt  = ($urandom_range(0, 39) == 0);
                s.evn  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                if ($urandom_range(0, 49) == 0) cfg_num = 3'($urandom_range(0, 7));
                applyStimulus(s);
                checkOutput($sformatf("rand_ep%0d_c%0d", ep, c), modelOut());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
